// File: rtl/spec_frame_packetizer.sv
// spec_frame_packetizer
// Buffers packed input words in a small word FIFO and emits them as framed byte
// packets: 4-byte header (MAGIC, seq, WORDS_PER_FRAME, IN_BYTES), then the payload
// bytes of WORDS_PER_FRAME words, byte [0] of each word first.
// Optional feature macro: PKT_CHECKSUM_EN appends an XOR checksum byte that carries m_tlast.
module spec_frame_packetizer #(
    parameter int          IN_BYTES        = 8,
    parameter int          WORDS_PER_FRAME = 4,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [7:0]  MAGIC           = 8'hA5
) (
    input  logic                  clk,
    input  logic                  arest,
    input  logic                  in_valid,
    input  logic [IN_BYTES*8-1:0] in_data,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  overflow,
    output logic [7:0]            frame_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BIDX_W = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_PAY
`ifdef PKT_CHECKSUM_EN
        , S_CSUM
`endif
    } state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 hdr_idx_q, hdr_idx_d;
    logic [BIDX_W-1:0]          byte_idx_q, byte_idx_d;
    logic [7:0]                 word_idx_q, word_idx_d;
    logic [7:0]                 seq_q, seq_d;
    logic [7:0]                 frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic                       overflow_q;
`ifdef PKT_CHECKSUM_EN
    logic [7:0]                 csum_q, csum_d;
`endif

    logic [IN_BYTES-1:0][7:0]   mem_q [FIFO_DEPTH];
    logic [IN_BYTES-1:0][7:0]   head_word;
    logic                       full, wr_en, rd_en, fire, last_pay_byte, frame_done;

    // "full" is taken from the registered count, so it ignores any pop in the same cycle.
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign wr_en     = in_valid & ~full;
    assign fire      = m_tvalid & m_tready;
    assign head_word = mem_q[rd_ptr_q];
    assign overflow  = overflow_q;
    assign frame_cnt = frame_cnt_q;
    assign last_pay_byte = (byte_idx_q == BIDX_W'(IN_BYTES - 1)) &&
                           (word_idx_q == 8'(WORDS_PER_FRAME - 1));

    // Word storage: data only, no reset.
    // NOTE: the memory array is deliberately left out of reset; the pointers and count
    // define which entries are live, and a resettable array would cost a reset net per bit.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data;
    end

    // FIFO pointers and the sticky overflow flag.
    // NOTE: all state is updated with non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge arest) begin
        if (arest) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en)           wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
            if (rd_en)           rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
            if (in_valid & full) overflow_q <= 1'b1;
        end
    end

    // Output byte mux: outputs depend only on registered state and the FIFO head,
    // so they hold still while the sink stalls.
    always_comb begin
        m_tvalid = (state_q != S_IDLE);
        m_tdata  = 8'h00;
        m_tlast  = 1'b0;
        case (state_q)
            S_HDR: begin
                case (hdr_idx_q)
                    2'd0:    m_tdata = MAGIC;
                    2'd1:    m_tdata = seq_q;
                    2'd2:    m_tdata = 8'(WORDS_PER_FRAME);
                    default: m_tdata = 8'(IN_BYTES);
                endcase
            end
            S_PAY: begin
                m_tdata = head_word[byte_idx_q];
`ifndef PKT_CHECKSUM_EN
                m_tlast = last_pay_byte;
`endif
            end
`ifdef PKT_CHECKSUM_EN
            S_CSUM: begin
                m_tdata = csum_q;
                m_tlast = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Framing FSM next-state, byte/word indexing, pop request and FIFO occupancy.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        byte_idx_d  = byte_idx_q;
        word_idx_d  = word_idx_q;
        seq_d       = seq_q;
        frame_cnt_d = frame_cnt_q;
        rd_en       = 1'b0;
        frame_done  = 1'b0;
`ifdef PKT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A whole frame must be buffered before the header goes out.
                if (count_q >= CNT_W'(WORDS_PER_FRAME)) begin
                    state_d   = S_HDR;
                    hdr_idx_d = 2'd0;
`ifdef PKT_CHECKSUM_EN
                    csum_d    = 8'h00;
`endif
                end
            end
            S_HDR: begin
                if (fire) begin
`ifdef PKT_CHECKSUM_EN
                    csum_d = csum_q ^ m_tdata;
`endif
                    if (hdr_idx_q == 2'd3) begin
                        state_d    = S_PAY;
                        byte_idx_d = '0;
                        word_idx_d = 8'd0;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end
            S_PAY: begin
                if (fire) begin
`ifdef PKT_CHECKSUM_EN
                    csum_d = csum_q ^ m_tdata;
`endif
                    if (byte_idx_q == BIDX_W'(IN_BYTES - 1)) begin
                        rd_en      = 1'b1;
                        byte_idx_d = '0;
                        word_idx_d = word_idx_q + 8'd1;
                        if (last_pay_byte) begin
`ifdef PKT_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            frame_done = 1'b1;
`endif
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + BIDX_W'(1);
                    end
                end
            end
`ifdef PKT_CHECKSUM_EN
            S_CSUM: begin
                if (fire) frame_done = 1'b1;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);

        // Chain straight into the next header when another frame is already buffered.
        if (frame_done) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            seq_d       = seq_q + 8'd1;
            hdr_idx_d   = 2'd0;
`ifdef PKT_CHECKSUM_EN
            csum_d      = 8'h00;
`endif
            state_d     = (count_d >= CNT_W'(WORDS_PER_FRAME)) ? S_HDR : S_IDLE;
        end
    end

    // Framing state registers.
    always_ff @(posedge clk or posedge arest) begin
        if (arest) begin
            state_q     <= S_IDLE;
            hdr_idx_q   <= 2'd0;
            byte_idx_q  <= '0;
            word_idx_q  <= 8'd0;
            seq_q       <= 8'd0;
            frame_cnt_q <= 8'd0;
            count_q     <= '0;
`ifdef PKT_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            byte_idx_q  <= byte_idx_d;
            word_idx_q  <= word_idx_d;
            seq_q       <= seq_d;
            frame_cnt_q <= frame_cnt_d;
            count_q     <= count_d;
`ifdef PKT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule
